// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Each one-cycle received-byte pulse is captured into a circular FIFO.
// The head entry is presented on a first-word-fall-through valid/ready port.
// The FIFO reports its fill level, full/empty/almost_full status and a sticky overrun flag.
// Optional feature macro: UART_RX_FIFO_BREAK_TAG_EN. When it is defined, the
// BREAK flag is stored alongside each byte. When it is undefined, BREAK words
// are discarded.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4,
  parameter int HIGH_WATER = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_break,
  input  logic                 flush,
  input  logic                 overrun_clr,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_break,
  input  logic                 out_ready,
  output logic [ADDR_BITS:0]   level,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overrun
);

`ifdef UART_RX_FIFO_BREAK_TAG_EN
  localparam int ENTRY_BITS = DATA_BITS + 1;
`else
  localparam int ENTRY_BITS = DATA_BITS;
`endif

  localparam logic [ADDR_BITS:0] HIGH_WATER_L = (ADDR_BITS+1)'(HIGH_WATER);

  logic [ENTRY_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS:0]    wr_ptr_reg;
  logic [ADDR_BITS:0]    rd_ptr_reg;
  logic                  overrun_reg;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [ENTRY_BITS-1:0] wr_entry;
  logic [ENTRY_BITS-1:0] head_entry;

`ifdef UART_RX_FIFO_BREAK_TAG_EN
  // A BREAK word occupies a slot, and its tag is kept in the top bit of the entry.
  assign accept   = in_valid;
  assign wr_entry = {in_break, in_data};
`else
  // A BREAK word is ignored entirely. It is not pushed and it does not count as an overrun.
  assign accept   = in_valid && !in_break;
  assign wr_entry = in_data;
`endif

  // Status is derived from the registered pointers. The MSB of each pointer is the wrap bit.
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_reg[ADDR_BITS-1:0]) &&
                       (wr_ptr_reg[ADDR_BITS] != rd_ptr_reg[ADDR_BITS]);
  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign almost_full = (level >= HIGH_WATER_L);
  assign out_valid   = !empty;
  assign overrun     = overrun_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte while it is being drained.
  assign pop  = out_valid && out_ready;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  // The head entry is read combinationally. It is forced to zero while the FIFO
  // is empty, so that stale storage never shows up on the output.
  assign head_entry = mem[rd_ptr_reg[ADDR_BITS-1:0]];
  assign out_data   = out_valid ? head_entry[DATA_BITS-1:0] : '0;
`ifdef UART_RX_FIFO_BREAK_TAG_EN
  assign out_break  = out_valid ? head_entry[DATA_BITS] : 1'b0;
`else
  assign out_break  = 1'b0;
`endif

  // Storage write. A flush discards the byte that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[ADDR_BITS-1:0]] <= wr_entry;
    end
  end

  // Pointer and overrun state. Flush has priority over push and pop, and a drop
  // takes precedence over overrun_clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, HIGH_WATER=12, DATA_BITS=8).
// Table vectors cover single-cycle behaviour. Hand-written sequences cover fill,
// overrun, wrap, flush, BREAK handling and asynchronous reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       flush;
  logic       overrun_clr;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_break;
  logic       out_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(
    .DATA_BITS(8), .DEPTH(16), .ADDR_BITS(4), .HIGH_WATER(12)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_break(in_break), .flush(flush), .overrun_clr(overrun_clr),
    .out_valid(out_valid), .out_data(out_data), .out_break(out_break),
    .out_ready(out_ready), .level(level), .empty(empty), .full(full),
    .almost_full(almost_full), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       fl;
    logic       oc;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_full;
    logic       e_af;
    logic       e_ovr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic fl,
                              input logic oc, input logic rdy, input logic ev,
                              input logic [7:0] ed, input logic [4:0] el,
                              input logic ef, input logic eaf, input logic eo);
    vec_t r;
    r.iv = iv; r.id = id; r.fl = fl; r.oc = oc; r.rdy = rdy;
    r.e_valid = ev; r.e_data = ed; r.e_level = el; r.e_full = ef; r.e_af = eaf; r.e_ovr = eo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm, input logic ev, input logic [7:0] ed,
                             input logic [4:0] el, input logic ef, input logic eaf,
                             input logic eo, input logic eb);
    chk({nm, "_valid"}, 32'(out_valid), 32'(ev));
    chk({nm, "_data"}, 32'(out_data), 32'(ed));
    chk({nm, "_level"}, 32'(level), 32'(el));
    chk({nm, "_empty"}, 32'(empty), 32'(el == 5'd0));
    chk({nm, "_full"}, 32'(full), 32'(ef));
    chk({nm, "_afull"}, 32'(almost_full), 32'(eaf));
    chk({nm, "_overrun"}, 32'(overrun), 32'(eo));
    chk({nm, "_break"}, 32'(out_break), 32'(eb));
  endtask

  // Drive one cycle of inputs, then sample #1 after the clock edge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ib,
                      input logic fl, input logic oc, input logic rdy);
    in_valid = iv; in_data = id; in_break = ib; flush = fl; overrun_clr = oc; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_break = 1'b0;
    flush = 1'b0; overrun_clr = 1'b0; out_ready = 1'b0;

    // Test 1 and test 5 (level 5 then flush with 0x33), plus push+pop at partial fill.
    vecs[0]  = mk(1, 8'h55, 0, 0, 0,  1, 8'h55, 5'd1, 0, 0, 0);
    vecs[1]  = mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 5'd0, 0, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 5'd0, 0, 0, 0);
    vecs[3]  = mk(1, 8'h01, 0, 0, 0,  1, 8'h01, 5'd1, 0, 0, 0);
    vecs[4]  = mk(1, 8'h02, 0, 0, 0,  1, 8'h01, 5'd2, 0, 0, 0);
    vecs[5]  = mk(1, 8'h03, 0, 0, 0,  1, 8'h01, 5'd3, 0, 0, 0);
    vecs[6]  = mk(1, 8'h04, 0, 0, 0,  1, 8'h01, 5'd4, 0, 0, 0);
    vecs[7]  = mk(1, 8'h05, 0, 0, 0,  1, 8'h01, 5'd5, 0, 0, 0);
    vecs[8]  = mk(1, 8'h33, 1, 0, 0,  0, 8'h00, 5'd0, 0, 0, 0);
    vecs[9]  = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 5'd0, 0, 0, 0);
    vecs[10] = mk(1, 8'hA1, 0, 0, 0,  1, 8'hA1, 5'd1, 0, 0, 0);
    vecs[11] = mk(1, 8'hA2, 0, 0, 0,  1, 8'hA1, 5'd2, 0, 0, 0);
    vecs[12] = mk(1, 8'hA3, 0, 0, 1,  1, 8'hA2, 5'd2, 0, 0, 0);
    vecs[13] = mk(0, 8'h00, 0, 0, 1,  1, 8'hA3, 5'd1, 0, 0, 0);
    vecs[14] = mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 5'd0, 0, 0, 0);

    // The reset state is checked both during reset and after it is released.
    #3;
    check_state("reset_in", 0, 8'h00, 5'd0, 0, 0, 0, 0);
    #9;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset_out", 0, 8'h00, 5'd0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].iv, vecs[i].id, 1'b0, vecs[i].fl, vecs[i].oc, vecs[i].rdy);
      check_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_level, vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovr, 1'b0);
      $display("vec %0d: level=%0d out_valid=%0d out_data=0x%02h", i, level, out_valid, out_data);
    end

    // Test 2: fill with 0x00..0x0F. almost_full asserts from the 12th push, and full asserts on the 16th.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      check_state($sformatf("fill%0d", i), 1, 8'h00, 5'(i + 1), i == 15, (i + 1) >= 12, 0, 0);
      $display("fill %0d: level=%0d", i, level);
    end
    step(1, 8'hAA, 0, 0, 0, 0);
    check_state("drop_aa", 1, 8'h00, 5'd16, 1, 1, 1, 0);
    $display("drop 0xAA: overrun=%0d level=%0d", overrun, level);

    // Test 4: a drop in the same cycle as overrun_clr wins. overrun_clr on its own clears the flag.
    step(1, 8'hBB, 0, 0, 1, 0);
    check_state("clr_drop", 1, 8'h00, 5'd16, 1, 1, 1, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    check_state("clr_alone", 1, 8'h00, 5'd16, 1, 1, 0, 0);
    $display("overrun_clr sequence: overrun=%0d", overrun);

    // Test 3: while full, a push and a pop happen together, so the level stays at 16.
    step(1, 8'h77, 0, 0, 0, 1);
    check_state("full_pushpop", 1, 8'h01, 5'd16, 1, 1, 0, 0);
    // Drain test: expect 0x01..0x0F in order, then 0x77.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_data", i), 32'(out_data), (i < 15) ? 32'(i + 1) : 32'h77);
      step(0, 8'h00, 0, 0, 0, 1);
      chk($sformatf("drain%0d_level", i), 32'(level), 32'(15 - i));
      $display("drain %0d: level=%0d", i, level);
    end
    check_state("drained", 0, 8'h00, 5'd0, 0, 0, 0, 0);

    // Three full passes starting from a non-zero pointer, which exercises the wrap logic.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + p * 16 + i), 0, 0, 0, 0);
      chk($sformatf("pass%0d_full", p), 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("pass%0d_rd%0d", p, i), 32'(out_data), 32'(8'h40 + p * 16 + i));
        step(0, 8'h00, 0, 0, 0, 1);
      end
      chk($sformatf("pass%0d_empty", p), 32'(empty), 32'd1);
      $display("pass %0d: done, level=%0d", p, level);
    end

    // A flush while full with overrun set clears the contents and the overrun flag, and discards 0x33.
    for (int i = 0; i < 17; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
    check_state("pre_flush", 1, 8'h10, 5'd16, 1, 1, 1, 0);
    step(1, 8'h33, 0, 1, 0, 0);
    check_state("flush", 0, 8'h00, 5'd0, 0, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0, 0);
    check_state("post_flush", 1, 8'h44, 5'd1, 0, 0, 0, 0);
    $display("flush: level=%0d out_data=0x%02h", level, out_data);
    step(0, 8'h00, 0, 0, 0, 1);

    // Test 6: a BREAK word with in_data = 0x00.
    step(1, 8'h00, 1, 0, 0, 0);
`ifdef UART_RX_FIFO_BREAK_TAG_EN
    check_state("break_word", 1, 8'h00, 5'd1, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
`else
    check_state("break_word", 0, 8'h00, 5'd0, 0, 0, 0, 0);
`endif
    $display("break word: out_valid=%0d out_break=%0d", out_valid, out_break);

    // An asynchronous reset in mid-operation discards the contents immediately.
    step(1, 8'h61, 0, 0, 0, 0);
    step(1, 8'h62, 0, 0, 0, 0);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_state("async_reset", 0, 8'h00, 5'd0, 0, 0, 0, 0);
    #4;
    resetn = 1'b1;
    step(1, 8'h66, 0, 0, 0, 0);
    check_state("after_reset", 1, 8'h66, 5'd1, 0, 0, 0, 0);
    $display("async reset: level=%0d out_data=0x%02h", level, out_data);
    step(0, 8'h00, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
